// File: rtl/y86_alu_if.sv
// y86_alu_if: operand/result bundle between the execute-stage operand select
// logic (master) and the Y86-64 ALU (slave).
//   control  : 2-bit op select (00 add, 01 sub, 10 and, 11 xor), master -> slave
//   a, b     : signed operands, master -> slave
//   set_cc   : load the condition codes from the current result, master -> slave
//   c        : combinational result, slave -> master
//   overflow : combinational signed overflow, slave -> master
//   zf/sf/of : registered condition codes, slave -> master
interface y86_alu_if #(
    parameter int WIDTH = 64
);
    logic [1:0]       control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             set_cc;
    logic [WIDTH-1:0] c;
    logic             overflow;
    logic             zf;
    logic             sf;
    logic             of;

    modport master (
        output control, a, b, set_cc,
        input  c, overflow, zf, sf, of
    );

    modport slave (
        input  control, a, b, set_cc,
        output c, overflow, zf, sf, of
    );
endinterface

// File: rtl/y86_alu.sv
// y86_alu: 64-bit integer ALU for the Y86-64 execute stage.
//   clk    : rising-edge clock, used only by the condition-code register
//   rst_n  : asynchronous active-low reset, clears zf/sf/of
//   alu    : y86_alu_if slave port
//            control/a/b -> c/overflow combinationally (wrap modulo 2^WIDTH)
//            set_cc=1 loads zf/sf/of from the current result on the next clk rise
module y86_alu #(
    parameter int WIDTH = 64
) (
    input logic      clk,
    input logic      rst_n,
    y86_alu_if.slave alu
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             zf_q, sf_q, of_q;
    logic             zf_d, sf_d, of_d;

    // Result and signed overflow. Overflow is detected from sign bits only:
    // add overflows when like-signed operands give a differently signed
    // result; sub overflows when unlike-signed operands give a result whose
    // sign differs from the minuend.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (alu_op_e'(alu.control))
            OP_ADD: begin
                res = alu.a + alu.b;
                ovf = (alu.a[MSB] == alu.b[MSB]) && (res[MSB] != alu.a[MSB]);
            end
            OP_SUB: begin
                res = alu.a - alu.b;
                ovf = (alu.a[MSB] != alu.b[MSB]) && (res[MSB] != alu.a[MSB]);
            end
            OP_AND: res = alu.a & alu.b;
            OP_XOR: res = alu.a ^ alu.b;
            default: begin
                res = '0;
                ovf = 1'b0;
            end
        endcase
    end

    // Condition-code next state: capture on set_cc, otherwise hold.
    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (alu.set_cc) begin
            zf_d = (res == '0);
            sf_d = res[MSB];
            of_d = ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign alu.c        = res;
    assign alu.overflow = ovf;
    assign alu.zf       = zf_q;
    assign alu.sf       = sf_q;
    assign alu.of       = of_q;
endmodule

// File: tb/tb_y86_alu.sv
module tb_y86_alu;
    logic clk;
    logic rst_n;

    y86_alu_if #(.WIDTH(64)) bus ();

    y86_alu #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected condition codes, maintained by the bench
    logic m_zf, m_sf, m_of;

    typedef struct {
        string       name;
        logic [1:0]  ctl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_c;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on 66-bit signed values, overflow
    // is "true result outside the 64-bit signed range".
    task automatic model(input logic [1:0] ctl, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic ov);
        logic signed [65:0] full;
        logic signed [65:0] xs, ys;
        logic signed [65:0] maxv, minv;
        xs   = {{2{x[63]}}, x};
        ys   = {{2{y[63]}}, y};
        maxv = 66'sd9223372036854775807;
        minv = -maxv - 66'sd1;
        full = '0;
        ov   = 1'b0;
        case (ctl)
            2'b00: full = xs + ys;
            2'b01: full = xs - ys;
            2'b10: full = xs & ys;
            default: full = xs ^ ys;
        endcase
        r = full[63:0];
        if (ctl == 2'b00 || ctl == 2'b01)
            ov = (full > maxv) || (full < minv);
    endtask

    task automatic drive(input logic [1:0] ctl, input logic [63:0] x, input logic [63:0] y,
                         input logic scc);
        bus.control = ctl;
        bus.a       = x;
        bus.b       = y;
        bus.set_cc  = scc;
        #1;
    endtask

    // one rising edge, sample 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".zf"}, {63'd0, bus.zf}, {63'd0, m_zf});
        chk({tag, ".sf"}, {63'd0, bus.sf}, {63'd0, m_sf});
        chk({tag, ".of"}, {63'd0, bus.of}, {63'd0, m_of});
    endtask

    initial begin
        logic [63:0] r;
        logic        ov;

        vecs[0] = '{"add5_7",    2'b00, 64'd5,                 64'd7,                 64'd12,                1'b0};
        vecs[1] = '{"sub_rsp",   2'b01, 64'h100,               64'd8,                 64'hF8,                1'b0};
        vecs[2] = '{"sub_zero",  2'b01, 64'd42,                64'd42,                64'd0,                 1'b0};
        vecs[3] = '{"add_ovf",   2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,               64'h8000_0000_0000_0000, 1'b1};
        vecs[4] = '{"sub_ovf",   2'b01, 64'h8000_0000_0000_0000, 64'd1,               64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{"neg_min",   2'b01, 64'd0,                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
        vecs[6] = '{"wrap0",     2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,               64'd0,                 1'b0};
        vecs[7] = '{"and",       2'b10, 64'hF0F0,              64'hFF00,              64'hF000,              1'b0};
        vecs[8] = '{"xor",       2'b11, 64'hF0F0,              64'hFF00,              64'h0FF0,              1'b0};
        vecs[9] = '{"sub_neg",   2'b01, 64'd3,                 64'd5,                 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};

        // reset state
        rst_n = 1'b0;
        m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
        drive(2'b00, 64'd0, 64'd0, 1'b1);
        tick();
        chk_flags("reset");
        #3 rst_n = 1'b1;

        // directed table: combinational result, then load flags
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ctl, vecs[i].a, vecs[i].b, 1'b1);
            chk({vecs[i].name, ".c"}, bus.c, vecs[i].exp_c);
            chk({vecs[i].name, ".ov"}, {63'd0, bus.overflow}, {63'd0, vecs[i].exp_ov});
            tick();
            m_zf = (vecs[i].exp_c == 64'd0);
            m_sf = vecs[i].exp_c[63];
            m_of = vecs[i].exp_ov;
            chk_flags(vecs[i].name);
        end

        // flag hold: load sf=1/of=1, then zero result with set_cc=0
        drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        tick();
        m_zf = 1'b0; m_sf = 1'b1; m_of = 1'b1;
        chk_flags("hold_pre");
        drive(2'b01, 64'd42, 64'd42, 1'b0);
        chk("hold.c", bus.c, 64'd0);
        for (int k = 0; k < 3; k++) tick();
        chk_flags("hold");

        // async reset mid-cycle with flags set
        tick();
        #2 rst_n = 1'b0;
        #1;
        m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
        chk_flags("async_rst");
        // reset wins over set_cc at an edge
        drive(2'b01, 64'd7, 64'd7, 1'b1);
        tick();
        chk_flags("rst_wins");
        #2 rst_n = 1'b1;
        // c is combinational and unaffected by reset
        chk("rst.c", bus.c, 64'd0);

        // randomized against the reference model
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  ctl;
            logic [63:0] x, y;
            logic        scc;
            ctl = 2'($urandom_range(0, 3));
            x   = {$urandom, $urandom};
            y   = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: x = 64'h7FFF_FFFF_FFFF_FFFF;
                1: x = 64'h8000_0000_0000_0000;
                2: y = x;
                3: y = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            scc = 1'($urandom_range(0, 1));
            drive(ctl, x, y, scc);
            model(ctl, x, y, r, ov);
            chk("rnd.c", bus.c, r);
            chk("rnd.ov", {63'd0, bus.overflow}, {63'd0, ov});
            tick();
            if (scc) begin
                m_zf = (r == 64'd0);
                m_sf = r[63];
                m_of = ov;
            end
            chk_flags("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
